save_uploader: RTL and testbench

SAVE_UPLOADER -- requirements
Module: save_uploader

---
 rtl/save_uploader_if.sv | 36 +++
 rtl/save_uploader.sv | 164 ++++++++++++++++
 tb/tb_save_uploader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/save_uploader_if.sv
// ---------------------------------------------------------------------------
// save_uploader_if
// HPS file-upload (ioctl) bundle between the HPS bridge and save_uploader.
//
// Signals:
//   ioctl_upload  HPS upload session active
//   ioctl_index   HPS file index of the session
//   ioctl_addr    byte address requested by the HPS
//   ioctl_rd      one-cycle read request for ioctl_addr
//   ioctl_din     byte returned to the HPS
//   ioctl_wait    high while the requested byte is not yet valid
//
// Handshake: ioctl_rd is a one-cycle request. If the responder raises
// ioctl_wait in the following cycle, ioctl_din becomes valid in the cycle
// where ioctl_wait drops again. If ioctl_wait does not rise, ioctl_din is
// already valid in the cycle after ioctl_rd. The requester issues no new
// ioctl_rd while ioctl_wait is high.
// ---------------------------------------------------------------------------
interface save_uploader_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/save_uploader.sv
// ---------------------------------------------------------------------------
// save_uploader
// Serves cartridge save RAM to the HPS during an upload session, and asks
// the HPS to upload (save_req) once the console has stopped writing save
// RAM for IDLE_CYCLES cycles.
//
// Ports:
//   clk_sys      system clock, all logic on its rising edge
//   reset_n      synchronous active-low reset
//   cart_save    save type: 1 high-score (2048 B), 2 SaveKey (32768 B),
//                anything else means no save RAM
//   ioctl        HPS upload bundle (slave side)
//   sram_addr    save-RAM read address (data returns one cycle later)
//   sram_q       save-RAM read data
//   core_we      one-cycle pulse per console write to save RAM
//   save_req     level request to the HPS to upload the save data
//   upload_busy  registered "upload to this block in progress"
//   dbg_state    read FSM state: 0 IDLE, 1 ADDR, 2 WAIT, 3 HOLD
// ---------------------------------------------------------------------------
module save_uploader #(
  parameter int         ADDR_W      = 15,
  parameter int         IDLE_CYCLES = 7159090,
  parameter logic [7:0] SAVE_INDEX  = 8'd1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [7:0]          cart_save,
  save_uploader_if.slave      ioctl,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic [7:0]          sram_q,
  input  logic                core_we,
  output logic                save_req,
  output logic                upload_busy,
  output logic [1:0]          dbg_state
);

  localparam int LIM_W = ADDR_W + 1;
  // IDLE_CYCLES-1 always fits in clog2(IDLE_CYCLES) bits.
  localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } rd_state_t;

  rd_state_t         state, state_nx;
  logic [7:0]        din_nx;
  logic              wait_nx;
  logic [ADDR_W-1:0] sram_addr_nx;

  logic              sel;
  logic              save_en;
  logic [LIM_W-1:0]  limit;
  logic              in_range;
  logic              busy_fall;
  logic              dirty;
  logic [CNT_W-1:0]  quiet_cnt;

  assign sel       = ioctl.ioctl_upload & (ioctl.ioctl_index == SAVE_INDEX);
  assign save_en   = (cart_save == 8'd1) | (cart_save == 8'd2);
  assign in_range  = ioctl.ioctl_addr < 25'(limit);
  // upload_busy still high while sel has already dropped: the edge where
  // upload_busy falls.
  assign busy_fall = upload_busy & ~sel;
  assign dbg_state = state;

  always_comb begin
    limit = '0;
    case (cart_save)
      8'd1:    limit = LIM_W'(2048);
      8'd2:    limit = LIM_W'(32768);
      default: limit = '0;
    endcase
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      ioctl.ioctl_din  <= 8'h00;
      ioctl.ioctl_wait <= 1'b0;
      sram_addr        <= '0;
    end else begin
      state            <= state_nx;
      ioctl.ioctl_din  <= din_nx;
      ioctl.ioctl_wait <= wait_nx;
      sram_addr        <= sram_addr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    din_nx       = ioctl.ioctl_din;
    wait_nx      = ioctl.ioctl_wait;
    sram_addr_nx = sram_addr;
    if (!sel) begin
      // Session ended or switched to another file: abandon any read,
      // keep the last byte on ioctl_din.
      state_nx = ST_IDLE;
      wait_nx  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (ioctl.ioctl_rd) begin
            if (in_range) begin
              // The address register is loaded on acceptance so it is on
              // sram_addr throughout ADDR; the RAM answers during WAIT.
              state_nx     = ST_ADDR;
              wait_nx      = 1'b1;
              sram_addr_nx = ioctl.ioctl_addr[ADDR_W-1:0];
            end else begin
              // Beyond the save size: answer immediately with erased data.
              state_nx = ST_HOLD;
              din_nx   = 8'hFF;
              wait_nx  = 1'b0;
            end
          end
        end
        ST_ADDR: state_nx = ST_WAIT;
        ST_WAIT: begin
          din_nx   = sram_q;
          wait_nx  = 1'b0;
          state_nx = ST_HOLD;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // ---------------- dirty tracking / save request ----------------
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      upload_busy <= 1'b0;
      dirty       <= 1'b0;
      quiet_cnt   <= '0;
      save_req    <= 1'b0;
    end else begin
      upload_busy <= sel;
      if (!save_en) begin
        dirty     <= 1'b0;
        quiet_cnt <= '0;
        save_req  <= 1'b0;
      end else if (busy_fall) begin
        // Upload finished: data is saved, unless a write lands right now.
        save_req  <= 1'b0;
        dirty     <= core_we;
        quiet_cnt <= core_we ? CNT_RELOAD : '0;
      end else if (core_we) begin
        dirty     <= 1'b1;
        quiet_cnt <= CNT_RELOAD;
      end else if (dirty) begin
        if (quiet_cnt != '0) begin
          quiet_cnt <= quiet_cnt - 1'b1;
        end else if (!upload_busy) begin
          save_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_save_uploader.sv
// ---------------------------------------------------------------------------
// tb_save_uploader
// Self-checking bench for save_uploader with a short quiet time. Reads are
// checked per transaction against a RAM image and the save-size rules;
// save_req and upload_busy are checked every cycle against an event model
// built on write timestamps and deadlines.
// ---------------------------------------------------------------------------
module tb_save_uploader;
  localparam int         ADDR_W = 15;
  localparam int         IDLE   = 8;
  localparam logic [7:0] IDX    = 8'd1;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  logic [7:0]        cart_save;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_q;
  logic              core_we;
  logic              save_req;
  logic              upload_busy;
  logic [1:0]        dbg_state;

  save_uploader_if ioctl ();

  save_uploader #(
    .ADDR_W      (ADDR_W),
    .IDLE_CYCLES (IDLE),
    .SAVE_INDEX  (IDX)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cart_save   (cart_save),
    .ioctl       (ioctl),
    .sram_addr   (sram_addr),
    .sram_q      (sram_q),
    .core_we     (core_we),
    .save_req    (save_req),
    .upload_busy (upload_busy),
    .dbg_state   (dbg_state)
  );

  // Save RAM with one cycle of read latency.
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk_sys) sram_q <= ram[sram_addr];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int lim_of(input logic [7:0] c);
    if (c == 8'd1) return 2048;
    if (c == 8'd2) return 32768;
    return 0;
  endfunction

  // Save-request model: every write opens a deadline IDLE+1 cycles later.
  int cyc = 0;
  int deadline = 0;
  bit dirty_m = 0, req_m = 0, busy_m = 0, sel_m;
  bit mon_en = 0;

  always @(posedge clk_sys) begin
    sel_m = ioctl.ioctl_upload && (ioctl.ioctl_index == IDX);
    if (!reset_n) begin
      dirty_m = 0; req_m = 0; busy_m = 0;
    end else begin
      if (lim_of(cart_save) == 0) begin
        dirty_m = 0; req_m = 0;
      end else if (busy_m && !sel_m) begin
        req_m   = 0;
        dirty_m = core_we;
        if (core_we) deadline = cyc + IDLE + 1;
      end else if (core_we) begin
        dirty_m  = 1;
        deadline = cyc + IDLE + 1;
      end else if (dirty_m && !busy_m && (cyc + 1 >= deadline)) begin
        req_m = 1;
      end
      busy_m = sel_m;
    end
    cyc++;
  end

  always @(negedge clk_sys) begin
    if (mon_en) begin
      chk("save_req", save_req, req_m);
      chk("upload_busy", upload_busy, busy_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sel_on();
    ioctl.ioctl_upload = 1'b1;
    ioctl.ioctl_index  = IDX;
  endtask

  task automatic pulse_we();
    core_we = 1'b1;
    step();
    core_we = 1'b0;
  endtask

  // One HPS read; intrude issues a stray ioctl_rd while the read is in ADDR.
  task automatic do_read(input int a, input bit intrude);
    logic [7:0]        exp;
    logic [ADDR_W-1:0] sa_prev;
    bit                inr;
    sa_prev = sram_addr;
    inr     = a < lim_of(cart_save);
    exp     = inr ? ram[a] : 8'hFF;
    ioctl.ioctl_addr = 25'(a);
    ioctl.ioctl_rd   = 1'b1;
    step();
    ioctl.ioctl_rd = 1'b0;
    if (inr) begin
      chk("rd_wait_rise", ioctl.ioctl_wait, 1);
      if (intrude) begin
        ioctl.ioctl_rd   = 1'b1;
        ioctl.ioctl_addr = 25'($urandom_range(0, 2047));
      end
      step();
      ioctl.ioctl_rd = 1'b0;
      chk("rd_sram_addr", sram_addr, a);
      chk("rd_wait_hold", ioctl.ioctl_wait, 1);
      step();
      chk("rd_din", ioctl.ioctl_din, exp);
      chk("rd_wait_fall", ioctl.ioctl_wait, 0);
    end else begin
      chk("oob_din", ioctl.ioctl_din, 8'hFF);
      chk("oob_wait", ioctl.ioctl_wait, 0);
      chk("oob_sram_addr", sram_addr, sa_prev);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] din_prev;
  int         r;

  initial begin
    reset_n = 1'b0; cart_save = 8'd0; core_we = 1'b0;
    ioctl.ioctl_upload = 1'b0; ioctl.ioctl_index = 8'd0;
    ioctl.ioctl_addr = '0; ioctl.ioctl_rd = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
    ram[5] = 8'hA7;
    repeat (3) step();
    chk("rst_din", ioctl.ioctl_din, 8'h00);
    chk("rst_wait", ioctl.ioctl_wait, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_save_req", save_req, 0);
    chk("rst_busy", upload_busy, 0);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // High-score reads: directed byte, boundary, then random addresses.
    cart_save = 8'd1;
    sel_on();
    step();
    do_read(5, 0);
    chk("din_a7", ioctl.ioctl_din, 8'hA7);
    do_read(2047, 0);
    do_read(2048, 0);
    for (int i = 0; i < 24; i++) do_read($urandom_range(0, 4095), 1'($urandom_range(0, 1)));

    // SaveKey reads around the 32 KB boundary.
    cart_save = 8'd2;
    do_read(32767, 0);
    do_read(32768, 0);
    for (int i = 0; i < 12; i++) do_read($urandom_range(0, 40000), 1'($urandom_range(0, 1)));

    // No save RAM: everything reads as erased.
    cart_save = 8'd3;
    do_read(0, 0);
    cart_save = 8'd0;
    do_read(100, 0);

    // Read on another file index is ignored.
    cart_save = 8'd2;
    ioctl.ioctl_index = 8'd0;
    step();
    din_prev = ioctl.ioctl_din;
    ioctl.ioctl_addr = 25'd10;
    ioctl.ioctl_rd   = 1'b1;
    step();
    ioctl.ioctl_rd = 1'b0;
    chk("nosel_state", dbg_state, 0);
    chk("nosel_wait", ioctl.ioctl_wait, 0);
    chk("nosel_din", ioctl.ioctl_din, din_prev);

    // Session dropped mid-read.
    sel_on();
    step();
    ioctl.ioctl_rd = 1'b1;
    step();
    ioctl.ioctl_rd = 1'b0;
    ioctl.ioctl_upload = 1'b0;
    step();
    chk("drop_state", dbg_state, 0);
    chk("drop_wait", ioctl.ioctl_wait, 0);
    chk("drop_din", ioctl.ioctl_din, din_prev);

    // Reset in the middle of a read (WAIT).
    sel_on();
    step();
    do_read(7, 0);
    ioctl.ioctl_addr = 25'd9;
    ioctl.ioctl_rd   = 1'b1;
    step();
    ioctl.ioctl_rd = 1'b0;
    step();
    chk("pre_rst_wait", ioctl.ioctl_wait, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_state", dbg_state, 0);
    chk("midrst_wait", ioctl.ioctl_wait, 0);
    chk("midrst_din", ioctl.ioctl_din, 8'h00);
    ioctl.ioctl_upload = 1'b0;
    step();

    // Quiet time after a single write.
    cart_save = 8'd1;
    pulse_we();
    for (int k = 1; k <= 12; k++) begin
      chk("req_single", save_req, (k >= 9) ? 1 : 0);
      step();
    end
    // Upload four bytes; request clears as the session ends.
    sel_on();
    step();
    for (int i = 0; i < 4; i++) do_read(i, 0);
    ioctl.ioctl_upload = 1'b0;
    step();
    chk("req_clear", save_req, 0);
    step();
    chk("req_clear2", save_req, 0);

    // A second write restarts the quiet time.
    pulse_we();
    repeat (4) step();
    pulse_we();
    for (int k = 6; k <= 15; k++) begin
      chk("req_restart", save_req, (k >= 14) ? 1 : 0);
      step();
    end

    // Write coincident with the end of the upload wins.
    sel_on();
    step();
    do_read(3, 0);
    ioctl.ioctl_upload = 1'b0;
    core_we = 1'b1;
    step();
    core_we = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      chk("req_coincide", save_req, (k >= 9) ? 1 : 0);
      step();
    end
    sel_on();
    step();
    ioctl.ioctl_upload = 1'b0;
    step();

    // Write during an upload: no request, cleared when the upload ends.
    sel_on();
    step();
    pulse_we();
    repeat (12) step();
    chk("req_busy", save_req, 0);
    ioctl.ioctl_upload = 1'b0;
    repeat (12) step();
    chk("req_busy_end", save_req, 0);

    // No save RAM: writes are ignored.
    cart_save = 8'd0;
    pulse_we();
    repeat (12) step();
    chk("req_nosave", save_req, 0);

    // Random traffic, checked cycle by cycle by the model.
    cart_save = 8'd1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        ioctl.ioctl_upload = ~ioctl.ioctl_upload;
        ioctl.ioctl_index  = ($urandom_range(0, 3) == 0) ? 8'd2 : IDX;
        step();
      end else if (r == 1) begin
        pulse_we();
      end else if (r == 2) begin
        cart_save = 8'($urandom_range(0, 3));
        step();
      end else if (r <= 5 && ioctl.ioctl_upload && ioctl.ioctl_index == IDX) begin
        do_read($urandom_range(0, 3000), 1'($urandom_range(0, 1)));
      end else begin
        step();
      end
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
